// File: rtl/gpio_ctrl_v2.sv
// Wishbone GPIO controller: per-pin output enable, atomic set/clear/toggle,
// synchronised inputs and per-pin edge/level interrupts with a W1C status register.
module gpio_ctrl_v2 #(
  parameter int              GW          = 32,
  parameter int              SYNC_STAGES = 2,
  parameter logic [GW-1:0]   RST_OUT     = '0,
  parameter logic [GW-1:0]   RST_OE      = '0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [5:0]    wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_inta_o,
  input  logic [GW-1:0] i_gpio,
  output logic [GW-1:0] o_gpio,
  output logic [GW-1:0] en_gpio
);

  logic [SYNC_STAGES*GW-1:0] sync_chain_reg;
  logic [GW-1:0] sync_val;
  logic [GW-1:0] prev_reg;
  logic [GW-1:0] out_reg, out_next;
  logic [GW-1:0] oe_reg, oe_next;
  logic [GW-1:0] inte_reg, inte_next;
  logic [GW-1:0] ptrig_reg, ptrig_next;
  logic [GW-1:0] edge_reg, edge_next;
  logic [GW-1:0] ints_reg, ints_next;
  logic [GW-1:0] irq_hit;
  logic [GW-1:0] w1c_bits;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          inta_reg;
  logic [31:0]   dat_reg, dat_next;

  logic          accept;
  logic          wr_en;
  logic          mapped;
  logic [5:0]    reg_off;
  logic [31:0]   byte_mask;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [GW-1:0] wmask;
  logic [GW-1:0] wdat;

  assign sync_val = sync_chain_reg[SYNC_STAGES*GW-1 -: GW];

  // Interrupt condition per pin, from synchronised value and its one-cycle history
  for (genvar gi = 0; gi < GW; gi++) begin : g_irq
    logic hit_edge;
    logic hit_level;
    assign hit_edge    = ptrig_reg[gi] ? (sync_val[gi] & ~prev_reg[gi])
                                       : (~sync_val[gi] & prev_reg[gi]);
    assign hit_level   = ptrig_reg[gi] ? sync_val[gi] : ~sync_val[gi];
    assign irq_hit[gi] = inte_reg[gi] & (edge_reg[gi] ? hit_edge : hit_level);
  end

  always_comb begin
    byte_mask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wr_data    = wb_dat_i & byte_mask;
    wmask      = byte_mask[GW-1:0];
    wdat       = wr_data[GW-1:0];
    accept     = wb_cyc_i & wb_stb_i & ~ack_reg & ~err_reg;
    wr_en      = accept & wb_we_i;
    reg_off    = wb_adr_i & 6'h3C;
    out_next   = out_reg;
    oe_next    = oe_reg;
    inte_next  = inte_reg;
    ptrig_next = ptrig_reg;
    edge_next  = edge_reg;
    w1c_bits   = '0;
    rd_word    = '0;
    mapped     = 1'b1;
    case (reg_off)
      6'h00: rd_word[GW-1:0] = sync_val;
      6'h04: begin
        rd_word[GW-1:0] = out_reg;
        if (wr_en) out_next = (out_reg & ~wmask) | wdat;
      end
      6'h08: begin
        rd_word[GW-1:0] = oe_reg;
        if (wr_en) oe_next = (oe_reg & ~wmask) | wdat;
      end
      6'h0C: if (wr_en) out_next = out_reg | wdat;
      6'h10: if (wr_en) out_next = out_reg & ~wdat;
      6'h14: if (wr_en) out_next = out_reg ^ wdat;
      6'h18: begin
        rd_word[GW-1:0] = inte_reg;
        if (wr_en) inte_next = (inte_reg & ~wmask) | wdat;
      end
      6'h1C: begin
        rd_word[GW-1:0] = ptrig_reg;
        if (wr_en) ptrig_next = (ptrig_reg & ~wmask) | wdat;
      end
      6'h20: begin
        rd_word[GW-1:0] = edge_reg;
        if (wr_en) edge_next = (edge_reg & ~wmask) | wdat;
      end
      6'h24: begin
        rd_word[GW-1:0] = ints_reg;
        if (wr_en) w1c_bits = wdat;
      end
      default: mapped = 1'b0;
    endcase
    // A new interrupt condition overrides a simultaneous W1C on the same bit
    ints_next = (ints_reg & ~w1c_bits) | irq_hit;
    ack_next  = accept & mapped;
    err_next  = accept & ~mapped;
    dat_next  = (accept & mapped) ? rd_word : 32'h0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_chain_reg <= '0;
      prev_reg       <= '0;
      out_reg        <= RST_OUT;
      oe_reg         <= RST_OE;
      inte_reg       <= '0;
      ptrig_reg      <= '0;
      edge_reg       <= '0;
      ints_reg       <= '0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
      inta_reg       <= 1'b0;
      dat_reg        <= '0;
    end else begin
      sync_chain_reg <= {sync_chain_reg[(SYNC_STAGES-1)*GW-1:0], i_gpio};
      prev_reg       <= sync_val;
      out_reg        <= out_next;
      oe_reg         <= oe_next;
      inte_reg       <= inte_next;
      ptrig_reg      <= ptrig_next;
      edge_reg       <= edge_next;
      ints_reg       <= ints_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      inta_reg       <= |ints_reg;
      dat_reg        <= dat_next;
    end
  end

  assign wb_dat_o  = dat_reg;
  assign wb_ack_o  = ack_reg;
  assign wb_err_o  = err_reg;
  assign wb_inta_o = inta_reg;
  assign o_gpio    = out_reg;
  assign en_gpio   = oe_reg;

endmodule

// File: tb/tb_gpio_ctrl_v2.sv
// Bench for gpio_ctrl_v2 (8 pins): directed scenarios plus random bus/pin traffic
// checked every cycle against a register-level reference model.
module tb_gpio_ctrl_v2;

  localparam int          GW   = 8;
  localparam int          SS   = 2;
  localparam logic [7:0]  ROUT = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [5:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack, err, inta;
  logic [7:0]  pins;
  logic [7:0]  o_gpio, en_gpio;

  int total = 0;
  int bad   = 0;

  gpio_ctrl_v2 #(.GW(GW), .SYNC_STAGES(SS), .RST_OUT(ROUT), .RST_OE(8'h00)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err), .wb_inta_o(inta),
    .i_gpio(pins), .o_gpio(o_gpio), .en_gpio(en_gpio)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural registers plus the pin pipeline
  logic [7:0]  m_out, m_oe, m_inte, m_ptrig, m_edge, m_ints, m_prev;
  logic [7:0]  m_stage [SS];
  logic        m_ack, m_err, m_inta;
  logic [31:0] m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = ROUT; m_oe = 8'h00; m_inte = 8'h00; m_ptrig = 8'h00; m_edge = 8'h00;
    m_ints = 8'h00; m_prev = 8'h00; m_ack = 1'b0; m_err = 1'b0; m_inta = 1'b0; m_dat = '0;
    for (int s = 0; s < SS; s++) m_stage[s] = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input int r);
    case (r)
      0: return m_stage[SS-1];
      1: return m_out;
      2: return m_oe;
      6: return m_inte;
      7: return m_ptrig;
      8: return m_edge;
      9: return m_ints;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: predict next state from current inputs, step the clock, compare outputs
  task automatic cycle();
    logic [7:0]  cond, d8, k8, w1c;
    logic [7:0]  n_out, n_oe, n_inte, n_ptrig, n_edge, n_ints, sy;
    logic [31:0] bm, n_dat;
    logic        n_ack, n_err, hit;
    int          r;
    sy = m_stage[SS-1];
    cond = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (m_edge[n]) hit = m_ptrig[n] ? (sy[n] && !m_prev[n]) : (!sy[n] && m_prev[n]);
      else           hit = m_ptrig[n] ? sy[n] : !sy[n];
      if (m_inte[n] && hit) cond[n] = 1'b1;
    end
    bm = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    d8 = dat_i[7:0] & bm[7:0];
    k8 = bm[7:0];
    n_out = m_out; n_oe = m_oe; n_inte = m_inte; n_ptrig = m_ptrig; n_edge = m_edge;
    w1c = 8'h00; n_ack = 1'b0; n_err = 1'b0; n_dat = '0;
    if (cyc && stb && !m_ack && !m_err) begin
      r = int'(adr[5:2]);
      if (r > 9) n_err = 1'b1;
      else begin
        n_ack = 1'b1;
        n_dat = {24'h0, model_read(r)};
        if (we) begin
          case (r)
            1: n_out   = (m_out & ~k8) | d8;
            2: n_oe    = (m_oe & ~k8) | d8;
            3: n_out   = m_out | d8;
            4: n_out   = m_out & ~d8;
            5: n_out   = m_out ^ d8;
            6: n_inte  = (m_inte & ~k8) | d8;
            7: n_ptrig = (m_ptrig & ~k8) | d8;
            8: n_edge  = (m_edge & ~k8) | d8;
            9: w1c     = d8;
            default: ;
          endcase
        end
      end
    end
    n_ints = (m_ints & ~w1c) | cond;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      m_inta = |m_ints;
      m_prev = sy;
      for (int s = SS - 1; s > 0; s--) m_stage[s] = m_stage[s-1];
      m_stage[0] = pins;
      m_out = n_out; m_oe = n_oe; m_inte = n_inte; m_ptrig = n_ptrig; m_edge = n_edge;
      m_ints = n_ints; m_ack = n_ack; m_err = n_err; m_dat = n_dat;
    end
    chk("o_gpio", {24'h0, o_gpio}, {24'h0, m_out});
    chk("en_gpio", {24'h0, en_gpio}, {24'h0, m_oe});
    chk("inta", {31'h0, inta}, {31'h0, m_inta});
    chk("ack", {31'h0, ack}, {31'h0, m_ack});
    chk("err", {31'h0, err}, {31'h0, m_err});
    if (m_ack || m_err) chk("dat_o", dat_o, m_dat);
  endtask

  task automatic bus(input logic w, input logic [5:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic ak, output logic er);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    cycle();
    rd = dat_o; ak = ack; er = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
  endtask

  initial begin
    logic [31:0] rd;
    logic        ak, er;
    logic        e0, e1, e2;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0; pins = '0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst o_gpio", {24'h0, o_gpio}, 32'hA5);
    chk("rst en_gpio", {24'h0, en_gpio}, 32'h0);
    chk("rst ack/err/inta", {29'h0, ack, err, inta}, 32'h0);

    bus(1'b0, 6'h04, 4'hF, 32'h0, rd, ak, er);
    chk("read OUT ack", {31'h0, ak}, 32'h1);
    chk("read OUT data", rd, 32'hA5);

    bus(1'b1, 6'h04, 4'b0001, 32'h0000_00F0, rd, ak, er);
    bus(1'b1, 6'h0C, 4'hF, 32'h0F, rd, ak, er);
    bus(1'b1, 6'h10, 4'hF, 32'h30, rd, ak, er);
    bus(1'b1, 6'h14, 4'hF, 32'h81, rd, ak, er);
    bus(1'b0, 6'h04, 4'hF, 32'h0, rd, ak, er);
    chk("set/clr/tgl OUT", rd, 32'h4E);
    bus(1'b1, 6'h04, 4'b0000, 32'hFFFF_FFFF, rd, ak, er);
    bus(1'b0, 6'h04, 4'hF, 32'h0, rd, ak, er);
    chk("OUT sel=0 unchanged", rd, 32'h4E);

    // Rising-edge interrupt on pin 3 and its inta latency
    bus(1'b1, 6'h20, 4'hF, 32'h08, rd, ak, er);
    bus(1'b1, 6'h1C, 4'hF, 32'h08, rd, ak, er);
    bus(1'b1, 6'h18, 4'hF, 32'h08, rd, ak, er);
    pins[3] = 1'b1;
    cycle(); cycle(); cycle();
    chk("inta before SS+2", {31'h0, inta}, 32'h0);
    cycle();
    chk("inta at SS+2", {31'h0, inta}, 32'h1);
    bus(1'b0, 6'h24, 4'hF, 32'h0, rd, ak, er);
    chk("INTS edge", rd, 32'h08);
    bus(1'b1, 6'h24, 4'hF, 32'h08, rd, ak, er);
    chk("inta after W1C", {31'h0, inta}, 32'h0);

    // Level-low on pin 0
    bus(1'b1, 6'h18, 4'hF, 32'h09, rd, ak, er);
    bus(1'b1, 6'h24, 4'hF, 32'h01, rd, ak, er);
    bus(1'b0, 6'h24, 4'hF, 32'h0, rd, ak, er);
    chk("level re-set", rd & 32'h1, 32'h1);
    pins[0] = 1'b1;
    cycle(); cycle(); cycle();
    bus(1'b1, 6'h24, 4'hF, 32'h01, rd, ak, er);
    bus(1'b0, 6'h24, 4'hF, 32'h0, rd, ak, er);
    chk("level cleared", rd, 32'h0);

    // Rising edge lands on the same clock as the W1C commit
    pins[3] = 1'b0;
    cycle(); cycle(); cycle(); cycle();
    pins[3] = 1'b1;
    cycle(); cycle();
    bus(1'b1, 6'h24, 4'hF, 32'h08, rd, ak, er);
    bus(1'b0, 6'h24, 4'hF, 32'h0, rd, ak, er);
    chk("set beats W1C", rd, 32'h08);

    // Unmapped access
    bus(1'b1, 6'h28, 4'hF, 32'hFFFF_FFFF, rd, ak, er);
    chk("unmapped err", {30'h0, ak, er}, 32'h1);
    chk("unmapped dat", rd, 32'h0);
    bus(1'b0, 6'h04, 4'hF, 32'h0, rd, ak, er);
    chk("OUT after unmapped", rd, 32'h4E);
    bus(1'b0, 6'h08, 4'hF, 32'h0, rd, ak, er);
    chk("OE after unmapped", rd, 32'h0);

    // Held strobe alternates the response
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h28; sel = 4'hF;
    cycle(); e0 = err;
    cycle(); e1 = err;
    cycle(); e2 = err;
    chk("held stb err pattern", {29'h0, e0, e1, e2}, 32'h5);
    cyc = 1'b0; stb = 1'b0;
    cycle();

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      if ($urandom_range(0, 4) == 0) cycle();
      else bus(1'($urandom), {4'($urandom_range(0, 15)), 2'($urandom)}, 4'($urandom),
               $urandom, rd, ak, er);
    end

    // Reset in the middle of a write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h04; sel = 4'hF; dat_i = 32'h0;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ack", {30'h0, ack, err}, 32'h0);
    chk("async rst o_gpio", {24'h0, o_gpio}, 32'hA5);
    chk("async rst en/inta", {23'h0, en_gpio, inta}, 32'h0);
    cycle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    bus(1'b0, 6'h04, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst OUT", rd, 32'hA5);
    bus(1'b0, 6'h08, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst OE", rd, 32'h0);
    bus(1'b0, 6'h18, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst INTE", rd, 32'h0);
    bus(1'b0, 6'h1C, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst PTRIG", rd, 32'h0);
    bus(1'b0, 6'h20, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst EDGE", rd, 32'h0);
    bus(1'b0, 6'h24, 4'hF, 32'h0, rd, ak, er);
    chk("post-rst INTS", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
